eth_tx_arbiter: RTL

Shares the single 2-bit RMII transmit stream between two packet sources (e.g. the response packetizer and a status/ARP generator). Grants whole packets round-robin, forwards the granted source's dibits with one cycle of registered latency, and enforces the Ethernet inter-packet gap before the next grant. Sits between the packet builders and the transmit CRC/preamble stage, mirroring the receive-side filtering path.

---
 rtl/eth_pkg.sv | 19 +
 rtl/txarb_gap_timer.sv | 35 +++
 rtl/eth_tx_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet datapath types: RMII dibit, transmit-arbiter states and the standard inter-packet gap.
package eth_pkg;

    typedef logic [1:0] dibit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XMIT  = 2'd2,
        ST_GAP   = 2'd3
    } txarb_state_t;

    // 96 bit times at 2 bits per RMII cycle.
    localparam int ETH_IFG_DIBITS = 48;

    // Width of the inter-packet gap counter.
    localparam int TXARB_GAP_W = 8;

endpackage

// File: rtl/txarb_gap_timer.sv
// Loadable down-counter that saturates at zero; done_o is high while the count is zero.
module txarb_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/eth_tx_arbiter.sv
// Two-source RMII transmit arbiter: whole-packet round-robin grants, 1-cycle registered data path,
// enforced inter-packet gap. Define TXARB_TIMEOUT_EN to drop a grant whose source never starts sending.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int IFG_DIBITS    = ETH_IFG_DIBITS,
    parameter int START_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       axiiv0,
    input  logic [1:0] axiid0,
    input  logic       axiiv1,
    input  logic [1:0] axiid1,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy
);

    if ((IFG_DIBITS < 1) || (IFG_DIBITS > 255) || (START_TIMEOUT < 2) || (START_TIMEOUT > 65535)) begin : g_bad_param
        $error("eth_tx_arbiter: IFG_DIBITS or START_TIMEOUT out of range");
    end

    txarb_state_t state_q;
    logic         sel_q;
    logic         last_q;
    logic         gnt0_q;
    logic         gnt1_q;
    logic         axiov_q;
    dibit_t       axiod_q;

    logic         g_req;
    logic         g_vld;
    dibit_t       g_dat;
    logic         win;

    logic         gap_load;
    logic         gap_dec;
    logic         gap_done;

    always_comb begin
        g_req = sel_q ? req1   : req0;
        g_vld = sel_q ? axiiv1 : axiiv0;
        g_dat = sel_q ? axiid1 : axiid0;
        // On a tie the source that was not served last wins.
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
    end

    assign gap_load = (state_q == ST_XMIT) && !g_vld;
    assign gap_dec  = (state_q == ST_GAP);

    txarb_gap_timer #(
        .W (TXARB_GAP_W)
    ) u_gap (
        .clk    (clk),
        .rst    (rst),
        .load_i (gap_load),
        .val_i  (TXARB_GAP_W'(IFG_DIBITS - 1)),
        .dec_i  (gap_dec),
        .done_o (gap_done)
    );

`ifdef TXARB_TIMEOUT_EN
    localparam int TO_W = $clog2(START_TIMEOUT + 1);

    logic to_load;
    logic to_dec;
    logic to_done;

    assign to_load = (state_q == ST_IDLE) && (req0 || req1);
    assign to_dec  = (state_q == ST_GRANT);

    txarb_gap_timer #(
        .W (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load_i (to_load),
        .val_i  (TO_W'(START_TIMEOUT - 1)),
        .dec_i  (to_dec),
        .done_o (to_done)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
        end else begin
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        sel_q   <= win;
                        gnt0_q  <= ~win;
                        gnt1_q  <= win;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (g_vld) begin
                        axiov_q <= 1'b1;
                        axiod_q <= g_dat;
                        state_q <= ST_XMIT;
                    end else if (!g_req) begin
                        // Abandoned grant: priority is left untouched.
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`ifdef TXARB_TIMEOUT_EN
                    else if (to_done) begin
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        last_q  <= sel_q;
                        state_q <= ST_IDLE;
                    end
`endif
                end
                ST_XMIT: begin
                    if (g_vld) begin
                        axiov_q <= 1'b1;
                        axiod_q <= g_dat;
                    end else begin
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        last_q  <= sel_q;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign axiov = axiov_q;
    assign axiod = axiod_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
